pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
//  Combines predictor mispredict flush, load-use hazards, IMEM wait and DMEM handshake.
//  Drives per-register enable/bubble controls. Gates the branch-predictor update to
//  one pulse per retiring EX instruction, so a frozen EX never retrains BTB/counter.
// PARAMETERS
//  DMEM_TIMEOUT  255  max cycles in S_DMEM_WAIT before forced release + error pulse
//  CNT_W         32   width of perf counters (only with PIPE_PERF_CNT_EN)
// PORTS
//  i_clk           in   1   clock
//  i_rst_n         in   1   async active-low reset
//  i_flush_brc     in   1   mispredict from branch predictor (EX stage)
//  i_ID_rs1        in   5   ID source reg 1
//  i_ID_rs2        in   5   ID source reg 2
//  i_ID_rs_used    in   2   [0]=rs1 read, [1]=rs2 read
//  i_EX_rd         in   5   EX dest reg
//  i_EX_is_load    in   1   EX holds a load
//  i_imem_ready    in   1   IF fetch data valid this cycle
//  i_MEM_mem_vld   in   1   MEM holds load/store
//  i_dmem_ack      in   1   data memory completes access
//  o_pc_en         out  1   PC register update
//  o_IF_ID_en      out  1   IF/ID register load
//  o_IF_ID_bubble  out  1   IF/ID loads NOP
//  o_ID_EX_en      out  1   ID/EX register load
//  o_ID_EX_bubble  out  1   ID/EX loads NOP
//  o_EX_MEM_en     out  1   EX/MEM register load
//  o_MEM_WB_en     out  1   MEM/WB register load
//  o_MEM_WB_bubble out  1   MEM/WB loads NOP
//  o_dmem_req      out  1   data memory request strobe
//  o_bp_upd_en     out  1   predictor/BTB write enable
//  o_bus_err       out  1   one-cycle pulse on DMEM timeout
// BEHAVIOUR
//  Reset: state S_RUN, timeout cnt 0, all en=0, bubbles=1, o_dmem_req=0, o_bp_upd_en=0, o_bus_err=0.
//  First cycle after reset release: all en=1, bubbles=0.
//  FSM states S_RUN, S_DMEM_WAIT:
//   S_RUN: o_dmem_req = i_MEM_mem_vld.
//    If i_MEM_mem_vld & ~i_dmem_ack, go to S_DMEM_WAIT.
//    Same-cycle ack means zero-wait, no stall.
//   S_DMEM_WAIT: o_dmem_req=1.
//    All en=0 (full freeze); o_MEM_WB_bubble=1.
//    On i_dmem_ack: return to S_RUN; MEM/WB loads (en=1, bubble=0) this cycle.
//    Counter increments each wait cycle. On cnt==DMEM_TIMEOUT-1 without ack:
//    o_bus_err=1 for one cycle, release as if acked (MEM/WB bubble=1), counter cleared.
//  Load-use: hz = i_EX_is_load & i_EX_rd!=0 & rs match on a used port.
//  Priority (high->low), only when not frozen:
//   1. i_flush_brc -> pc_en=1, IF_ID_bubble=1, ID_EX_bubble=1; hz ignored (ID killed).
//   2. hz -> pc_en=0, IF_ID_en=0, ID_EX_bubble=1 for exactly 1 cycle.
//   3. ~i_imem_ready -> pc_en=0, IF_ID_bubble=1; downstream advances.
//  Freeze (S_DMEM_WAIT or leaving to it) overrides all three; i_flush_brc stays
//  asserted from the frozen EX and is applied on the release cycle.
//  o_bp_upd_en = i_EX advances (EX_MEM_en=1) & EX not a bubble. Max 1 pulse per instruction.
//  Reset mid-wait: FSM returns to S_RUN immediately; no o_bus_err.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//   adds o_cnt_mispred[CNT_W] (increments on applied flush) and
//   o_cnt_stall[CNT_W] (cycles with pc_en=0).
//   Saturating, reset 0.
//  PIPE_PERF_CNT_EN undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  Package pipe_ctrl_pkg: state_e enum {S_RUN,S_DMEM_WAIT}; ctrl_t struct of en/bubble
//   bits; localparam X0=5'd0.
//  Sub-module pipe_perf_cnt: saturating counter pair (only under macro).
//  Hazard compare and priority mux stay inline.
// TESTING
//  T1: load x5 in EX, ID reads rs1=x5 -> exactly 1 cycle pc_en=0, ID_EX_bubble=1.
//   Same with rd=x0 -> no stall.
//  T2: i_flush_brc=1 with hz=1 -> IF_ID_bubble=ID_EX_bubble=1, pc_en=1,
//   no stall; o_bp_upd_en=1 once.
//  T3: store in MEM, ack after 3 cycles -> 3 cycles all en=0, o_dmem_req held 3 cycles,
//   single o_bp_upd_en for frozen EX branch.
//  T4: DMEM_TIMEOUT=4, no ack -> o_bus_err pulse at 4th wait cycle, state S_RUN next,
//   MEM_WB_bubble=1.
//  T5: i_imem_ready=0 for 2 cycles -> two IF_ID bubbles, EX/MEM keep advancing.
//  T6: i_rst_n low mid-S_DMEM_WAIT -> outputs at reset values asynchronously;
//   with PIPE_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared types and helpers for the RV32I pipeline stall/flush
//             sequencer (FSM states, per-register control bundle).
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [4:0] X0 = 5'd0;

    typedef enum logic [0:0] {
        S_RUN       = 1'b0,
        S_DMEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_bubble;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t C_CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_bubble: 1'b1,
                                       id_ex_en: 1'b0, id_ex_bubble: 1'b1, ex_mem_en: 1'b0,
                                       mem_wb_en: 1'b0, mem_wb_bubble: 1'b1};

    localparam ctrl_t C_CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_bubble: 1'b0,
                                        id_ex_en: 1'b0, id_ex_bubble: 1'b0, ex_mem_en: 1'b0,
                                        mem_wb_en: 1'b0, mem_wb_bubble: 1'b1};

    localparam ctrl_t C_CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_bubble: 1'b0,
                                     id_ex_en: 1'b1, id_ex_bubble: 1'b0, ex_mem_en: 1'b1,
                                     mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};

    // x0 is hardwired zero, so a load targeting it can never create a hazard
    function automatic logic load_use_hit(input logic [4:0] rs, input logic used,
                                          input logic [4:0] rd);
        return used && (rs == rd) && (rd != X0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl_if
//  Purpose  : Datapath <-> pipeline controller signal bundle. Perf counter
//             outputs exist only when PIPE_PERF_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic       i_flush_brc;
    logic [4:0] i_ID_rs1;
    logic [4:0] i_ID_rs2;
    logic [1:0] i_ID_rs_used;
    logic [4:0] i_EX_rd;
    logic       i_EX_is_load;
    logic       i_imem_ready;
    logic       i_MEM_mem_vld;
    logic       i_dmem_ack;

    logic       o_pc_en;
    logic       o_IF_ID_en;
    logic       o_IF_ID_bubble;
    logic       o_ID_EX_en;
    logic       o_ID_EX_bubble;
    logic       o_EX_MEM_en;
    logic       o_MEM_WB_en;
    logic       o_MEM_WB_bubble;
    logic       o_dmem_req;
    logic       o_bp_upd_en;
    logic       o_bus_err;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] o_cnt_mispred;
    logic [CNT_W-1:0] o_cnt_stall;

    modport slave (
        input  i_flush_brc, i_ID_rs1, i_ID_rs2, i_ID_rs_used, i_EX_rd, i_EX_is_load,
               i_imem_ready, i_MEM_mem_vld, i_dmem_ack,
        output o_pc_en, o_IF_ID_en, o_IF_ID_bubble, o_ID_EX_en, o_ID_EX_bubble,
               o_EX_MEM_en, o_MEM_WB_en, o_MEM_WB_bubble, o_dmem_req, o_bp_upd_en,
               o_bus_err, o_cnt_mispred, o_cnt_stall
    );
    modport master (
        output i_flush_brc, i_ID_rs1, i_ID_rs2, i_ID_rs_used, i_EX_rd, i_EX_is_load,
               i_imem_ready, i_MEM_mem_vld, i_dmem_ack,
        input  o_pc_en, o_IF_ID_en, o_IF_ID_bubble, o_ID_EX_en, o_ID_EX_bubble,
               o_EX_MEM_en, o_MEM_WB_en, o_MEM_WB_bubble, o_dmem_req, o_bp_upd_en,
               o_bus_err, o_cnt_mispred, o_cnt_stall
    );
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = ^CNT_W;

    modport slave (
        input  i_flush_brc, i_ID_rs1, i_ID_rs2, i_ID_rs_used, i_EX_rd, i_EX_is_load,
               i_imem_ready, i_MEM_mem_vld, i_dmem_ack,
        output o_pc_en, o_IF_ID_en, o_IF_ID_bubble, o_ID_EX_en, o_ID_EX_bubble,
               o_EX_MEM_en, o_MEM_WB_en, o_MEM_WB_bubble, o_dmem_req, o_bp_upd_en,
               o_bus_err
    );
    modport master (
        output i_flush_brc, i_ID_rs1, i_ID_rs2, i_ID_rs_used, i_EX_rd, i_EX_is_load,
               i_imem_ready, i_MEM_mem_vld, i_dmem_ack,
        input  o_pc_en, o_IF_ID_en, o_IF_ID_bubble, o_ID_EX_en, o_ID_EX_bubble,
               o_EX_MEM_en, o_MEM_WB_en, o_MEM_WB_bubble, o_dmem_req, o_bp_upd_en,
               o_bus_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_perf_cnt
//  Purpose  : Pair of saturating event counters (mispredict flushes, PC stall
//             cycles). Present only when PIPE_PERF_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_inc_a,
    input  wire logic             i_inc_b,
    output logic      [CNT_W-1:0] o_cnt_a,
    output logic      [CNT_W-1:0] o_cnt_b
);
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (i_inc_a && (r_cnt_a != {CNT_W{1'b1}})) r_cnt_a <= r_cnt_a + 1'b1;
            if (i_inc_b && (r_cnt_b != {CNT_W{1'b1}})) r_cnt_b <= r_cnt_b + 1'b1;
        end
    end

    assign o_cnt_a = r_cnt_a;
    assign o_cnt_b = r_cnt_b;
endmodule
`endif
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Stall/flush sequencer for the 5-stage RV32I pipeline; optional
//             perf counters under PIPE_PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    pipeline_ctrl_if.slave  bus
);
    localparam int             TW          = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [TW-1:0]  C_TMO_LAST  = TW'(DMEM_TIMEOUT - 1);

    logic          r_active;
    state_e        r_state;
    logic [TW-1:0] r_wait_cnt;
    logic          r_id_bubble;
    logic          r_ex_bubble;

    logic          w_hz;
    logic          w_in_wait;
    logic          w_timeout;
    logic          w_freeze;
    ctrl_t         w_ctrl;

    assign w_hz = bus.i_EX_is_load &&
                  (load_use_hit(bus.i_ID_rs1, bus.i_ID_rs_used[0], bus.i_EX_rd) ||
                   load_use_hit(bus.i_ID_rs2, bus.i_ID_rs_used[1], bus.i_EX_rd));

    assign w_in_wait = (r_state == S_DMEM_WAIT);
    assign w_timeout = w_in_wait && !bus.i_dmem_ack && (r_wait_cnt == C_TMO_LAST);
    // The cycle that launches an unacked access already freezes the pipe
    assign w_freeze  = r_active &&
                       (w_in_wait ? (!bus.i_dmem_ack && !w_timeout)
                                  : (bus.i_MEM_mem_vld && !bus.i_dmem_ack));

    always_comb begin
        w_ctrl = C_CTRL_RESET;
        if (r_active) begin
            if (w_freeze) begin
                w_ctrl = C_CTRL_FREEZE;
            end else begin
                w_ctrl               = C_CTRL_RUN;
                w_ctrl.mem_wb_bubble = w_timeout;
                if (bus.i_flush_brc) begin
                    w_ctrl.if_id_bubble = 1'b1;
                    w_ctrl.id_ex_bubble = 1'b1;
                end else if (w_hz) begin
                    w_ctrl.pc_en        = 1'b0;
                    w_ctrl.if_id_en     = 1'b0;
                    w_ctrl.id_ex_bubble = 1'b1;
                end else if (!bus.i_imem_ready) begin
                    w_ctrl.pc_en        = 1'b0;
                    w_ctrl.if_id_bubble = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active    <= 1'b0;
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_id_bubble <= 1'b1;
            r_ex_bubble <= 1'b1;
        end else begin
            r_active <= 1'b1;
            if (r_active) begin
                case (r_state)
                    S_RUN: begin
                        r_wait_cnt <= '0;
                        if (bus.i_MEM_mem_vld && !bus.i_dmem_ack) r_state <= S_DMEM_WAIT;
                    end
                    S_DMEM_WAIT: begin
                        if (bus.i_dmem_ack || w_timeout) begin
                            r_state    <= S_RUN;
                            r_wait_cnt <= '0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_RUN;
                endcase
            end
            // Track NOP occupancy of ID and EX so a bubble never trains the predictor
            if (w_ctrl.if_id_en) r_id_bubble <= w_ctrl.if_id_bubble;
            if (w_ctrl.id_ex_en) r_ex_bubble <= w_ctrl.id_ex_bubble || r_id_bubble;
        end
    end

    assign bus.o_pc_en         = w_ctrl.pc_en;
    assign bus.o_IF_ID_en      = w_ctrl.if_id_en;
    assign bus.o_IF_ID_bubble  = w_ctrl.if_id_bubble;
    assign bus.o_ID_EX_en      = w_ctrl.id_ex_en;
    assign bus.o_ID_EX_bubble  = w_ctrl.id_ex_bubble;
    assign bus.o_EX_MEM_en     = w_ctrl.ex_mem_en;
    assign bus.o_MEM_WB_en     = w_ctrl.mem_wb_en;
    assign bus.o_MEM_WB_bubble = w_ctrl.mem_wb_bubble;
    assign bus.o_dmem_req      = r_active && (w_in_wait || bus.i_MEM_mem_vld);
    assign bus.o_bp_upd_en     = w_ctrl.ex_mem_en && !r_ex_bubble;
    assign bus.o_bus_err       = r_active && w_timeout;

`ifdef PIPE_PERF_CNT_EN
    logic w_flush_apl;
    logic w_stall_cyc;

    assign w_flush_apl = r_active && !w_freeze && bus.i_flush_brc;
    assign w_stall_cyc = r_active && !w_ctrl.pc_en;

    pipe_perf_cnt #(
        .CNT_W   (CNT_W)
    ) u_perf_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc_a (w_flush_apl),
        .i_inc_b (w_stall_cyc),
        .o_cnt_a (bus.o_cnt_mispred),
        .o_cnt_b (bus.o_cnt_stall)
    );
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule
`default_nettype wire
